// File: rtl/store_byte_arbiter_if.sv
// Request/grant/response bundle shared by the two requesters and store_byte_arbiter.
// master = requester side (bench), slave = arbiter side.
interface store_byte_arbiter_if #(
    parameter int unsigned ADDR_W = 2
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [7:0]        wdata0;
    logic [7:0]        wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              ack0;
    logic              ack1;
    logic [7:0]        rdata;
    logic              rd_valid;
    logic              busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, ack0, ack1, rdata, rd_valid, busy
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, ack0, ack1, rdata, rd_valid, busy
    );
endinterface

// File: rtl/store_byte_arbiter.sv
// Two-requester arbiter in front of a small byte store; IDLE -> ACCESS -> RESP per transaction.
// Define STORE_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties) instead of round-robin.
module store_byte_arbiter #(
    parameter int unsigned ADDR_W = 2
) (
    input logic                clk,
    input logic                rst,
    store_byte_arbiter_if.slave io_bus
);
    localparam int unsigned Depth = 1 << ADDR_W;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic              r_id;
    logic [7:0]        r_mem [Depth];
    logic [7:0]        r_rdata;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_rd_valid;
    logic              r_busy;
    logic              w_win;

`ifdef STORE_ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = ~io_bus.req0;
    end
`else
    logic r_last;

    // On a tie the requester not granted most recently wins.
    always_comb begin
        w_win = io_bus.req1;
        if (io_bus.req0 && io_bus.req1) begin
            w_win = ~r_last;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 8'h00;
            r_id       <= 1'b0;
            r_rdata    <= 8'h00;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            for (int unsigned i = 0; i < Depth; i++) begin
                r_mem[i[ADDR_W-1:0]] <= 8'h00;
            end
`ifndef STORE_ARB_FIXED_PRIO_EN
            r_last     <= 1'b1;
`endif
        end else begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (io_bus.req0 || io_bus.req1) begin
                        // Capture the winner's request so it may change after its grant.
                        r_id    <= w_win;
                        r_we    <= w_win ? io_bus.we1    : io_bus.we0;
                        r_addr  <= w_win ? io_bus.addr1  : io_bus.addr0;
                        r_wdata <= w_win ? io_bus.wdata1 : io_bus.wdata0;
                        r_gnt0  <= ~w_win;
                        r_gnt1  <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= StAccess;
`ifndef STORE_ARB_FIXED_PRIO_EN
                        r_last  <= w_win;
`endif
                    end
                end
                StAccess: begin
                    if (r_we) begin
                        r_mem[r_addr] <= r_wdata;
                    end else begin
                        r_rdata <= r_mem[r_addr];
                    end
                    r_ack0     <= ~r_id;
                    r_ack1     <= r_id;
                    r_rd_valid <= ~r_we;
                    r_state    <= StResp;
                end
                StResp: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign io_bus.gnt0     = r_gnt0;
    assign io_bus.gnt1     = r_gnt1;
    assign io_bus.ack0     = r_ack0;
    assign io_bus.ack1     = r_ack1;
    assign io_bus.rdata    = r_rdata;
    assign io_bus.rd_valid = r_rd_valid;
    assign io_bus.busy     = r_busy;
endmodule

// File: tb/tb_store_byte_arbiter.sv
// Scoreboard bench for store_byte_arbiter: the driver queues expected grants/acks,
// a negedge monitor pops and compares them and checks per-cycle invariants.
module tb_store_byte_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        bit         id;
        int         cyc;
        bit         rd;
        logic [7:0] data;
    } exp_t;

    exp_t       gq[$];
    exp_t       aq[$];
    logic [7:0] exp_mem [4];
    logic [7:0] exp_rdata;

    store_byte_arbiter_if #(.ADDR_W(2)) bus ();

    store_byte_arbiter #(.ADDR_W(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            logic g, a;
            g = bus.gnt0 | bus.gnt1;
            a = bus.ack0 | bus.ack1;
            check("one_hot", 32'((bus.gnt0 & bus.gnt1) | (bus.ack0 & bus.ack1) | (g & a)), 32'd0);
            check("busy", 32'(bus.busy), 32'(g | a));
            if (!a) check("rd_valid_no_ack", 32'(bus.rd_valid), 32'd0);
            if (g) begin
                if (gq.size() == 0) begin
                    check("gnt_unexpected", 32'd1, 32'd0);
                end else begin
                    e = gq.pop_front();
                    check("gnt_id", 32'(bus.gnt1), 32'(e.id));
                    check("gnt_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (a) begin
                if (aq.size() == 0) begin
                    check("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    e = aq.pop_front();
                    check("ack_id", 32'(bus.ack1), 32'(e.id));
                    check("ack_cycle", 32'(cyc), 32'(e.cyc));
                    check("rd_valid", 32'(bus.rd_valid), 32'(e.rd));
                    check("rdata", 32'(bus.rdata), 32'(e.data));
                end
            end
        end
    end

    // Called at a negedge: reset for one edge, then check the reset state.
    task automatic reset_pulse();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_mem[i] = 8'h00;
        exp_rdata = 8'h00;
        check("rst_gnt",  32'({bus.gnt0, bus.gnt1}), 32'd0);
        check("rst_ack",  32'({bus.ack0, bus.ack1}), 32'd0);
        check("rst_rdv",  32'(bus.rd_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
    endtask

    // One single-requester transaction; inputs are scrambled right after the grant.
    task automatic txn(input bit id, input bit we, input logic [1:0] addr, input logic [7:0] wd);
        exp_t e;
        @(negedge clk);
        if (id) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
        end
        e.id = id; e.cyc = cyc + 1; e.rd = !we; e.data = 8'h00;
        gq.push_back(e);
        if (we) exp_mem[addr] = wd;
        else    exp_rdata = exp_mem[addr];
        e.cyc = cyc + 2; e.data = exp_rdata;
        aq.push_back(e);
        @(negedge clk);
        if (id) begin
            bus.req1 = 1'b0; bus.we1 = ~we; bus.addr1 = ~addr; bus.wdata1 = 8'h00;
        end else begin
            bus.req0 = 1'b0; bus.we0 = ~we; bus.addr0 = ~addr; bus.wdata0 = 8'h00;
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   c;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = 2'd0; bus.addr1 = 2'd0; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
        @(negedge clk);
        reset_pulse();
        mon_en = 1'b1;

        // Basic write then readback on requester 0.
        txn(1'b0, 1'b1, 2'd1, 8'hA5);
        txn(1'b0, 1'b0, 2'd1, 8'h00);

        // Reset aborting a write in its ACCESS cycle.
        txn(1'b0, 1'b1, 2'd2, 8'h3C);
        txn(1'b0, 1'b0, 2'd2, 8'h00);
        @(negedge clk);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'd2; bus.wdata0 = 8'hFF;
        e.id = 1'b0; e.cyc = cyc + 1; e.rd = 1'b0; e.data = 8'h00;
        gq.push_back(e);
        @(negedge clk);
        bus.req0 = 1'b0;
        reset_pulse();
        txn(1'b0, 1'b0, 2'd2, 8'h00);

        // Requester 1 data changed after grant; cross-requester readback.
        txn(1'b1, 1'b1, 2'd3, 8'h5A);
        txn(1'b1, 1'b0, 2'd3, 8'h00);
        txn(1'b1, 1'b1, 2'd0, 8'hC3);
        txn(1'b0, 1'b0, 2'd0, 8'h00);

        // Both requesters held with reads: alternation (or fixed priority).
        @(negedge clk);
        reset_pulse();
        txn(1'b0, 1'b1, 2'd1, 8'h11);
        txn(1'b1, 1'b1, 2'd2, 8'h22);
        @(negedge clk);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 2'd1;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 2'd2;
        c = cyc;
        for (int k = 0; k < 4; k++) begin
`ifdef STORE_ARB_FIXED_PRIO_EN
            e.id = 1'b0;
`else
            e.id = (k % 2 == 1);
`endif
            e.rd = 1'b1; e.data = 8'h00; e.cyc = c + 1 + 3 * k;
            gq.push_back(e);
            e.data = e.id ? exp_mem[2] : exp_mem[1];
            e.cyc = c + 2 + 3 * k;
            aq.push_back(e);
        end
        repeat (10) @(negedge clk);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (4) @(negedge clk);

        check("gnt_queue_drained", 32'(gq.size()), 32'd0);
        check("ack_queue_drained", 32'(aq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/store_byte_arbiter.md
STORE_BYTE_ARBITER -- requirements
Module: store_byte_arbiter

Interface
REQ-001 Parameter ADDR_W, default 2, sets the byte-slot address width; depth is 2**ADDR_W bytes.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 req0, req1  input  1 each  access request from requester 0 / 1.
REQ-005 we0, we1  input  1 each  1=write, 0=read; sampled with the matching req.
REQ-006 addr0, addr1  input  ADDR_W each  byte-slot address.
REQ-007 wdata0, wdata1  input  8 each  write data.
REQ-008 gnt0, gnt1  output  1 each  registered one-cycle grant pulse.
REQ-009 ack0, ack1  output  1 each  registered one-cycle completion pulse.
REQ-010 rdata  output  8  read data; valid when rd_valid=1.
REQ-011 rd_valid  output  1  high exactly during an ack cycle of a read transaction.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 FSM states: IDLE, ACCESS, RESP; every transition occurs on rising clk.
REQ-014 IDLE, no req: remain in IDLE, all pulses low.
REQ-015 IDLE, at least one req at edge: latch the winner's we/addr/wdata and winner id, go to ACCESS, assert the winner's gnt for the ACCESS cycle only.
REQ-016 ACCESS: at the edge, a write stores the latched wdata into the addressed slot; a read loads the addressed slot into rdata; go to RESP.
REQ-017 RESP: winner's ack high for this cycle only, rd_valid=1 for reads; at the edge, return to IDLE.
REQ-018 Latency: req sampled at edge t -> gnt in cycle t+1 -> ack in cycle t+2; one transaction per 3 cycles maximum.
REQ-019 req is sampled only in IDLE; req held through RESP is re-arbitrated in the following IDLE cycle as a new transaction.
REQ-020 A requester's inputs may change after its gnt cycle without affecting the in-flight transaction.
REQ-021 Single req: that requester wins.
REQ-022 Both req (round-robin): winner is the requester not granted most recently; the last-granted pointer updates on each grant.
REQ-023 rdata holds its value across write transactions and idle cycles; it changes only on a read in ACCESS.
REQ-024 A read following a write to the same slot returns the newly written byte.
REQ-025 Never more than one gnt or one ack asserted in any cycle; gnt and ack never both high in the same cycle.

Reset
REQ-026 rst=1 at an edge: FSM to IDLE, all byte slots to 8'h00, rdata to 8'h00, all gnt/ack/rd_valid/busy low, last-granted pointer set so requester 0 wins the first tie.
REQ-027 rst during ACCESS or RESP aborts the transaction: no ack issued, no slot write committed at that edge.
REQ-028 rst has priority over every other input.

Configuration
REQ-029 Macro STORE_ARB_FIXED_PRIO_EN defined: requester 0 always wins a tie and the last-granted pointer is not implemented.
REQ-030 Macro STORE_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-022; all other behaviour is identical.

Verification
REQ-031 Reset then req0 write addr=1 wdata=8'hA5 -> gnt0 in cycle t+1, ack0 in cycle t+2, rd_valid=0; req0 read addr=1 -> rdata=8'hA5 with rd_valid=1 at ack0.
REQ-032 After reset, req0 and req1 both held high with reads -> grants alternate 0,1,0,1, one grant every 3 cycles (round-robin build).
REQ-033 Same stimulus with STORE_ARB_FIXED_PRIO_EN -> gnt0 only; gnt1 never asserts while req0 is high.
REQ-034 Write 8'h3C to addr 2, assert rst during the ACCESS of a write of 8'hFF to addr 2 -> no ack; a later read of addr 2 returns 8'h00.
REQ-035 req1 write addr=3 8'h5A, wdata1 changed to 8'h00 in the gnt1 cycle -> a later read of addr 3 returns 8'h5A; rdata unchanged during the write.
REQ-036 Scoreboard check across all tests: at most one gnt/ack per cycle; busy high exactly in the ACCESS and RESP cycles.
